// File: rtl/multdiv_seq_ctrl_pkg.sv
// Shared definitions for the iterative signed multiply/divide sequencer.
package multdiv_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        MD_IDLE = 3'd0,
        MD_MULT = 3'd1,
        MD_DIV  = 3'd2,
        MD_FIX  = 3'd3,
        MD_DONE = 3'd4
    } md_state_t;

    localparam int MD_ITERS = 32;
    localparam int MD_CNT_W = 5;
    localparam logic [MD_CNT_W-1:0] MD_LAST_ITER = MD_CNT_W'(MD_ITERS - 1);

    // Magnitude of a signed 32-bit value in 33 bits, so that the most
    // negative operand yields +2^31 without wrapping.
    function automatic logic [32:0] md_abs33(input logic [31:0] value);
        logic [32:0] extended;
        extended = {value[31], value};
        return value[31] ? (33'd0 - extended) : extended;
    endfunction

endpackage

// File: rtl/multdiv_iter_dp.sv
// Iteration datapath: shift registers plus one shared 33-bit add/subtract.
// Multiply: {hi,lo} is the running product, lo starts as the multiplier.
// Divide:   hi is the partial remainder, lo shifts the dividend out and the
//           quotient bits in (restoring division).
module multdiv_iter_dp
    import multdiv_seq_ctrl_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        load,
    input  logic        step,
    input  logic        op_sel,
    input  logic [31:0] a_mag,
    input  logic [32:0] b_mag,
    output logic [31:0] prod_hi,
    output logic [31:0] prod_lo
);

    logic [32:0] hi;
    logic [31:0] lo;
    logic [32:0] operand_b;
    logic [32:0] add_in;
    logic [32:0] add_op;
    logic [33:0] sum;

    // Shared adder: add the multiplicand when the multiplier bit is set, or
    // trial-subtract the divisor from the shifted partial remainder.
    always_comb begin
        add_in = hi;
        add_op = 33'd0;
        sum    = 34'd0;
        if (op_sel) begin
            add_in = {hi[31:0], lo[31]};
            add_op = operand_b;
            sum    = {1'b0, add_in} - {1'b0, add_op};
        end else begin
            add_in = hi;
            add_op = lo[0] ? operand_b : 33'd0;
            sum    = {1'b0, add_in} + {1'b0, add_op};
        end
    end

    // One bit per step; load clears the accumulator and captures operands.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hi        <= 33'd0;
            lo        <= 32'd0;
            operand_b <= 33'd0;
        end else if (load) begin
            hi        <= 33'd0;
            lo        <= a_mag;
            operand_b <= b_mag;
        end else if (step) begin
            if (!op_sel) begin
                hi <= {1'b0, sum[32:1]};
                lo <= {sum[0], lo[31:1]};
            end else if (sum[33]) begin
                hi <= add_in;
                lo <= {lo[30:0], 1'b0};
            end else begin
                hi <= sum[32:0];
                lo <= {lo[30:0], 1'b1};
            end
        end
    end

    assign prod_hi = hi[31:0];
    assign prod_lo = lo;

endmodule

// File: rtl/or_reduce32.sv
// 32-input OR-reduction; used (inverted) as the zero test throughout the unit.
module or_reduce32 (
    input  logic [31:0] data,
    output logic        any_set
);

    assign any_set = |data;

endmodule

// File: rtl/multdiv_seq_ctrl.sv
// Sequencer for the iterative signed multiply/divide unit. Only WIDTH=32 is
// supported: the iteration counter and zero tests are sized for 32 bits.
module multdiv_seq_ctrl
    import multdiv_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    md_state_t           state;
    md_state_t           next_state;
    logic [MD_CNT_W-1:0] counter;
    logic                neg_result;
    logic                op_is_div;
    logic                div_by_zero;
    logic [31:0]         result_q;
    logic                exception_q;

    logic        start;
    logic        start_mult;
    logic        start_div;
    logic        b_nonzero;
    logic        step;
    logic [31:0] a_mag;
    logic [32:0] b_mag;
    logic [31:0] prod_hi;
    logic [31:0] prod_lo;
    logic [63:0] product_mag;
    logic [63:0] signed_product;
    logic [31:0] quotient;
    logic        high_mismatch;
    logic [31:0] fix_result;
    logic        fix_exception;

    // MULT has priority when both start pulses arrive together.
    assign start      = ctrl_MULT | ctrl_DIV;
    assign start_mult = ctrl_MULT;
    assign start_div  = ctrl_DIV & ~ctrl_MULT;

    // Unsigned 32-bit negation gives 2^31 for 0x80000000, so A fits in 32 bits.
    assign a_mag = data_operandA[31] ? (32'd0 - data_operandA) : data_operandA;
    assign b_mag = md_abs33(data_operandB);

    or_reduce32 u_b_zero (
        .data    (data_operandB),
        .any_set (b_nonzero)
    );

    assign step = ((state == MD_MULT) || (state == MD_DIV)) && !start && !div_by_zero;

    multdiv_iter_dp u_dp (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (start),
        .step    (step),
        .op_sel  (op_is_div),
        .a_mag   (a_mag),
        .b_mag   (b_mag),
        .prod_hi (prod_hi),
        .prod_lo (prod_lo)
    );

    // Sign fix-up of the finished magnitude and overflow detection.
    always_comb begin
        product_mag    = {prod_hi, prod_lo};
        signed_product = neg_result ? (64'd0 - product_mag) : product_mag;
        quotient       = neg_result ? (32'd0 - prod_lo) : prod_lo;
        if (op_is_div) begin
            fix_result    = quotient;
            fix_exception = ~neg_result & prod_lo[31];
        end else begin
            fix_result    = signed_product[31:0];
            fix_exception = high_mismatch;
        end
    end

    or_reduce32 u_high_check (
        .data    (signed_product[63:32] ^ {32{signed_product[31]}}),
        .any_set (high_mismatch)
    );

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= MD_IDLE;
        else          state <= next_state;
    end

    // Next-state logic; a start in any state restarts the sequence.
    always_comb begin
        next_state = state;
        if (start_mult) begin
            next_state = MD_MULT;
        end else if (start_div) begin
            next_state = MD_DIV;
        end else begin
            case (state)
                MD_IDLE: next_state = MD_IDLE;
                MD_MULT: if (counter == MD_LAST_ITER) next_state = MD_FIX;
                MD_DIV:  begin
                    if (div_by_zero)                  next_state = MD_DONE;
                    else if (counter == MD_LAST_ITER) next_state = MD_FIX;
                end
                MD_FIX:  next_state = MD_DONE;
                MD_DONE: next_state = MD_IDLE;
                default: next_state = MD_IDLE;
            endcase
        end
    end

    // Per-operation control: captured on start, counter advances with each step.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            counter     <= '0;
            neg_result  <= 1'b0;
            op_is_div   <= 1'b0;
            div_by_zero <= 1'b0;
        end else if (start) begin
            counter     <= '0;
            neg_result  <= data_operandA[31] ^ data_operandB[31];
            op_is_div   <= start_div;
            div_by_zero <= start_div & ~b_nonzero;
        end else if (step) begin
            counter     <= counter + MD_CNT_W'(1);
        end
    end

    // Result registers update only when an operation completes; an aborting
    // start leaves the previous result in place.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            result_q    <= 32'd0;
            exception_q <= 1'b0;
        end else if (!start && state == MD_FIX) begin
            result_q    <= fix_result;
            exception_q <= fix_exception;
        end else if (!start && state == MD_DIV && div_by_zero) begin
            result_q    <= 32'd0;
            exception_q <= 1'b1;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exception_q;
    assign data_resultRDY = (state == MD_DONE);
    assign busy           = (state == MD_MULT) || (state == MD_DIV) || (state == MD_FIX);

endmodule

// File: tb/tb_multdiv_seq_ctrl.sv
// Self-checking bench for multdiv_seq_ctrl: directed corner cases plus
// randomized operations against an arithmetic reference model.
module tb_multdiv_seq_ctrl;

    logic        clock;
    logic        reset_n;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int assert_count = 0;
    int fail_count   = 0;

    multdiv_seq_ctrl #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single comparison point: counts and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Reference model straight from the arithmetic definition.
    task automatic modelOp(input bit is_mult, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] res, output logic exc);
        longint sa;
        longint sb;
        longint r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (is_mult) begin
            r   = sa * sb;
            res = r[31:0];
            exc = (r != longint'($signed(res)));
        end else if (b == 32'd0) begin
            res = 32'd0;
            exc = 1'b1;
        end else begin
            r   = sa / sb;
            res = r[31:0];
            exc = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        end
    endtask

    // Drive a one-cycle start pulse; returns #1 after the sampling edge.
    task automatic applyStimulus(input bit mult, input bit div, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        ctrl_MULT     = mult;
        ctrl_DIV      = div;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        #1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    // Launch an operation and check latency, busy duration, result and hold.
    task automatic runOp(input bit mult, input bit div, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [31:0] exp_res;
        logic        exp_exc;
        int          exp_lat;
        int          lat;
        int          busy_cycles;
        bit          seen;
        modelOp(mult, a, b, exp_res, exp_exc);
        exp_lat = (!mult && b == 32'd0) ? 2 : 34;
        applyStimulus(mult, div, a, b);
        lat = 0;
        busy_cycles = 0;
        seen = 1'b0;
        for (int c = 1; c <= 60 && !seen; c++) begin
            if (data_resultRDY) begin
                seen = 1'b1;
                lat  = c;
            end else begin
                if (busy) busy_cycles++;
                @(posedge clock);
                #1;
            end
        end
        checkOutput({tag, "_rdySeen"}, 32'(seen), 32'd1);
        checkOutput({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        checkOutput({tag, "_busyCycles"}, 32'(busy_cycles), 32'(exp_lat - 1));
        checkOutput({tag, "_busyAtRdy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_result"}, data_result, exp_res);
        checkOutput({tag, "_exception"}, 32'(data_exception), 32'(exp_exc));
        @(posedge clock);
        #1;
        checkOutput({tag, "_rdyPulse"}, 32'(data_resultRDY), 32'd0);
        checkOutput({tag, "_resultHeld"}, data_result, exp_res);
    endtask

    function automatic logic [31:0] pickOperand(input int mode);
        logic [31:0] specials [4];
        specials[0] = 32'h8000_0000;
        specials[1] = 32'hFFFF_FFFF;
        specials[2] = 32'h0000_0001;
        specials[3] = 32'h7FFF_FFFF;
        case (mode)
            0:       return $urandom;
            1:       return 32'($signed(32'($urandom_range(0, 2000))) - 1000);
            default: return specials[$urandom_range(0, 3)];
        endcase
    endfunction

    initial begin
        int          no_rdy;
        logic [31:0] ra;
        logic [31:0] rb;
        bit          rm;
        reset_n       = 1'b0;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = 32'd0;
        data_operandB = 32'd0;
        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset_result", data_result, 32'd0);
        checkOutput("reset_exception", 32'(data_exception), 32'd0);
        checkOutput("reset_rdy", 32'(data_resultRDY), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        $display("[TB] Directed operations");
        runOp(1, 0, 32'd7, 32'hFFFF_FFFA, "mult_7xm6");
        runOp(1, 0, 32'h0001_0000, 32'h0001_0000, "mult_ovf");
        runOp(1, 0, 32'h8000_0000, 32'd1, "mult_minx1");
        runOp(0, 1, 32'hFFFF_FFF9, 32'd2, "div_m7d2");
        runOp(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        runOp(0, 1, 32'd5, 32'd0, "div_by0");
        runOp(1, 1, 32'd9, 32'hFFFF_FFFD, "both_start");

        $display("[TB] Abort a multiply with a divide");
        applyStimulus(1, 0, 32'd123, 32'd456);
        for (int c = 1; c < 10; c++) begin
            checkOutput("abort_noEarlyRdy", 32'(data_resultRDY), 32'd0);
            @(posedge clock);
            #1;
        end
        runOp(0, 1, 32'd1000, 32'hFFFF_FFF9, "abort_div");

        $display("[TB] Randomized operations");
        for (int i = 0; i < 24; i++) begin
            rm = 1'($urandom_range(0, 1));
            ra = pickOperand($urandom_range(0, 2));
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : pickOperand($urandom_range(0, 2));
            runOp(rm, !rm, ra, rb, rm ? "rand_mult" : "rand_div");
        end

        $display("[TB] Reset in the middle of a divide");
        runOp(1, 0, 32'd11, 32'd13, "pre_reset");
        applyStimulus(0, 1, 32'd77, 32'd5);
        repeat (5) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        checkOutput("midreset_result", data_result, 32'd0);
        checkOutput("midreset_exception", 32'(data_exception), 32'd0);
        checkOutput("midreset_rdy", 32'(data_resultRDY), 32'd0);
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        no_rdy = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) no_rdy++;
        end
        checkOutput("postreset_noRdy", 32'(no_rdy), 32'd0);
        runOp(1, 0, 32'd3, 32'd4, "mult_3x4");

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
